// File: rtl/led_matrix_scanner_pkg.sv
// Shared matrix geometry, coordinate width and scan FSM encodings for the scanner and game top.
// Pure declarations: no latency, no flow control.
package led_matrix_scanner_pkg;

  localparam int DIM_X   = 6;
  localparam int DIM_Y   = 6;
  localparam int COORD_W = 3;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  function automatic logic coord_ok(input logic [COORD_W-1:0] v, input int lim);
    return int'(v) < lim;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_scan_timer.sv
// Loadable up counter: clears to 0 on i_clr, counts on i_en, o_tc flags count == i_limit.
// o_tc is combinational from the count register; no backpressure.
module led_matrix_scanner_scan_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == i_limit);

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scan controller for the 6x6 LED matrix with a ping-pong framebuffer swapped only at frame boundaries.
// Pins are registered from next-state (match the state of the same cycle); inputs never stall.
module led_matrix_scanner
  import led_matrix_scanner_pkg::*;
#(
  parameter int   N_ROWS       = DIM_Y,
  parameter int   N_COLS       = DIM_X,
  parameter int   DWELL_CYCLES = 2000,
  parameter int   BLANK_CYCLES = 16,
  parameter logic ROW_ACT      = 1'b1,
  parameter logic COL_ACT      = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic               wr_data,
  input  logic               clr,
  input  logic               swap_req,
  output logic               swap_ack,
  output logic               frame_start,
  output logic [N_ROWS-1:0]  row,
  output logic [N_COLS-1:0]  col
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [COORD_W-1:0] ROW_LAST   = COORD_W'(N_ROWS - 1);

  scan_state_t r_state, w_state_nxt;
  logic [COORD_W-1:0] r_row_idx, w_row_idx_nxt;
  logic r_run;
  logic r_sel;
  logic r_pend;
  logic [1:0][N_ROWS-1:0][N_COLS-1:0] r_buf;

  logic [CNT_W-1:0]  w_limit;
  logic              w_tc;
  logic              w_cnt_clr;
  logic              w_boundary;
  logic              w_wr_ok;
  logic [N_COLS-1:0] w_front_row;
  logic [N_ROWS-1:0] w_row_nxt;
  logic [N_COLS-1:0] w_col_nxt;

  led_matrix_scanner_scan_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_en    (r_run),
    .i_clr   (w_cnt_clr),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_BLANK;
      r_row_idx <= '0;
      r_run     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_idx <= w_row_idx_nxt;
      r_run     <= 1'b1;
    end
  end

  // The first edge after reset holds BLANK/row 0 and counts as a boundary so frame 0 gets its frame_start.
  always_comb begin
    w_state_nxt   = r_state;
    w_row_idx_nxt = r_row_idx;
    w_cnt_clr     = 1'b0;
    w_boundary    = 1'b0;
    w_limit       = (r_state == ST_BLANK) ? BLANK_LAST : DWELL_LAST;
    if (!r_run) begin
      w_boundary = 1'b1;
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (w_tc) begin
            w_state_nxt = ST_DRIVE;
            w_cnt_clr   = 1'b1;
          end
        end
        ST_DRIVE: begin
          if (w_tc) begin
            w_state_nxt = ST_BLANK;
            w_cnt_clr   = 1'b1;
            if (r_row_idx == ROW_LAST) begin
              w_row_idx_nxt = '0;
              w_boundary    = 1'b1;
            end else begin
              w_row_idx_nxt = r_row_idx + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_BLANK;
          w_cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  // A request landing on the boundary edge itself stays pending for the following boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel       <= 1'b0;
      r_pend      <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_boundary;
      swap_ack    <= w_boundary & r_pend;
      if (w_boundary) begin
        r_pend <= swap_req;
        if (r_pend) begin
          r_sel <= ~r_sel;
        end
      end else begin
        r_pend <= r_pend | swap_req;
      end
    end
  end

  assign w_wr_ok = coord_ok(wr_x, N_COLS) && coord_ok(wr_y, N_ROWS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf <= '0;
    end else if (clr) begin
      r_buf[~r_sel] <= '0;
    end else if (wr_en && w_wr_ok) begin
      r_buf[~r_sel][wr_y][wr_x] <= wr_data;
    end
  end

  assign w_front_row = r_buf[r_sel][w_row_idx_nxt];

  always_comb begin
    w_row_nxt = {N_ROWS{~ROW_ACT}};
    w_col_nxt = {N_COLS{~COL_ACT}};
    if (w_state_nxt == ST_DRIVE) begin
      w_row_nxt[w_row_idx_nxt] = ROW_ACT;
      for (int c = 0; c < N_COLS; c++) begin
        w_col_nxt[c] = w_front_row[c] ? COL_ACT : ~COL_ACT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= {N_ROWS{~ROW_ACT}};
      col <= {N_COLS{~COL_ACT}};
    end else begin
      row <= w_row_nxt;
      col <= w_col_nxt;
    end
  end

endmodule
